mtm_alu_serial_rx: RTL and testbench

Parametrised serial input deserialiser and packet checker for the mtm ALU. It samples the one-bit-per-clock `sin` line and decodes 11-bit frames. It assembles operand B and operand A from DATA frames and validates the closing CTL frame (frame count, CRC-4, opcode). It then presents parallel operands/opcode, or a one-hot error, to the ALU core and response serialiser. It generalises the fixed 32-bit receiver to any byte-multiple word width, selectable wire bit order, and an inter-frame timeout.

---
 rtl/mtm_alu_pkg.sv | 37 +++
 rtl/mtm_alu_crc4.sv | 24 ++
 rtl/mtm_alu_serial_rx.sv | 176 +++++++++++++++++
 tb/tb_mtm_alu_serial_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared constants, FSM state type and opcode helper for the mtm ALU serial path.
package mtm_alu_pkg;

  // ALU opcodes
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Frame layout: start, cmd, 8 payload bits, stop
  localparam int unsigned FRAME_BITS   = 11;
  localparam int unsigned PAYLOAD_BITS = FRAME_BITS - 3;
  localparam logic        CMD_DATA     = 1'b0;
  localparam logic        CMD_CTL      = 1'b1;

  // One-hot error vector bit positions: {err_data, err_crc, err_op}
  localparam int unsigned ERR_IDX_OP   = 0;
  localparam int unsigned ERR_IDX_CRC  = 1;
  localparam int unsigned ERR_IDX_DATA = 2;

  // Error response bytes sent back by the ALU transmitter
  localparam logic [7:0] ERR_DATA = 8'b11001001;
  localparam logic [7:0] ERR_CRC  = 8'b10100101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD,
    ST_STOP
  } rx_state_e;

  // True for the four opcodes the ALU core implements
  function automatic logic op_is_valid(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_crc4.sv
// Combinational CRC-4 (x^4+x+1) update over DATA_W message bits, MSB first.
module mtm_alu_crc4
  import mtm_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        crc_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [3:0]        crc_out
);

  logic w_fb;

  // Unrolled serial LFSR: feedback is top CRC bit xor incoming message bit
  always_comb begin
    crc_out = crc_in;
    w_fb    = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      w_fb    = crc_out[3] ^ data_in[DATA_W-1-i];
      crc_out = {crc_out[2:0], 1'b0} ^ {2'b00, w_fb, w_fb};
    end
  end

endmodule

// File: rtl/mtm_alu_serial_rx.sv
// Serial frame deserialiser and packet checker feeding the mtm ALU core.
module mtm_alu_serial_rx
  import mtm_alu_pkg::*;
#(
  parameter int unsigned WORD_W      = 32,
  parameter bit          LSB_FIRST   = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic [WORD_W-1:0] a_out,
  output logic [WORD_W-1:0] b_out,
  output logic [2:0]        op_out,
  output logic              valid,
  output logic [2:0]        err_out,
  output logic              err_valid
);

  localparam int unsigned WORD_BYTES = WORD_W / 8;
  localparam int unsigned NBYTES     = 2 * WORD_BYTES;
  localparam int unsigned CNT_MAX    = NBYTES + 1;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam int unsigned PKT_W      = 2 * WORD_W;
  localparam int unsigned BIT_CNT_W  = $clog2(PAYLOAD_BITS);
  localparam int unsigned TMO_W      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic                 r_cmd;
  logic [7:0]           r_shift;
  logic [PKT_W-1:0]     r_data;
  logic [CNT_W-1:0]     r_byte_cnt;
  logic [3:0]           r_crc;
  logic                 r_poison;
  logic [TMO_W-1:0]     r_tmo;

  logic                 w_last_bit;
  logic                 w_data_done;
  logic                 w_ctl_done;
  logic                 w_pkt_active;
  logic [CNT_W-1:0]     w_byte_cnt_inc;
  logic [2:0]           w_ctl_op;
  logic [3:0]           w_ctl_crc;
  logic [3:0]           w_crc_byte;
  logic [3:0]           w_crc_tail;
  logic                 w_err_data;
  logic                 w_err_crc;
  logic                 w_err_op;
  logic [2:0]           w_err_vec;

  // CRC step for a completed DATA byte and fold of the {1, OP} tail at CTL
  mtm_alu_crc4 #(.DATA_W(8)) u_crc_byte (
    .crc_in  (r_crc),
    .data_in (r_shift),
    .crc_out (w_crc_byte)
  );

  mtm_alu_crc4 #(.DATA_W(4)) u_crc_tail (
    .crc_in  (r_crc),
    .data_in ({1'b1, w_ctl_op}),
    .crc_out (w_crc_tail)
  );

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Frame next-state logic and CTL evaluation
  always_comb begin
    w_state_nxt    = r_state;
    w_last_bit     = (r_bit_cnt == BIT_CNT_W'(PAYLOAD_BITS - 1));
    w_data_done    = (r_state == ST_STOP) && (r_cmd == CMD_DATA);
    w_ctl_done     = (r_state == ST_STOP) && (r_cmd == CMD_CTL);
    w_pkt_active   = (r_byte_cnt != '0) || r_poison;
    w_byte_cnt_inc = (r_byte_cnt == CNT_W'(CNT_MAX)) ? r_byte_cnt : r_byte_cnt + CNT_W'(1);
    w_ctl_op       = r_shift[6:4];
    w_ctl_crc      = r_shift[3:0];
    w_err_data     = (r_byte_cnt != CNT_W'(NBYTES)) || r_poison || !sin || r_shift[7];
    w_err_crc      = (w_ctl_crc != w_crc_tail);
    w_err_op       = !op_is_valid(w_ctl_op);
    w_err_vec      = '0;

    case (r_state)
      ST_IDLE:    if (!sin) w_state_nxt = ST_CMD;
      ST_CMD:     w_state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: if (w_last_bit) w_state_nxt = ST_STOP;
      ST_STOP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase

    if (w_err_data)     w_err_vec[ERR_IDX_DATA] = 1'b1;
    else if (w_err_crc) w_err_vec[ERR_IDX_CRC]  = 1'b1;
    else if (w_err_op)  w_err_vec[ERR_IDX_OP]   = 1'b1;
  end

  // Datapath: shifting, packet accumulation, result registers and timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_cmd      <= 1'b0;
      r_shift    <= '0;
      r_data     <= '0;
      r_byte_cnt <= '0;
      r_crc      <= '0;
      r_poison   <= 1'b0;
      r_tmo      <= '0;
      a_out      <= '0;
      b_out      <= '0;
      op_out     <= '0;
      valid      <= 1'b0;
      err_out    <= '0;
      err_valid  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      err_valid <= 1'b0;

      case (r_state)
        ST_IDLE: r_bit_cnt <= '0;
        ST_CMD:  r_cmd <= sin;
        ST_PAYLOAD: begin
          r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
          if (LSB_FIRST) r_shift <= {sin, r_shift[7:1]};
          else           r_shift <= {r_shift[6:0], sin};
        end
        default: ;
      endcase

      // Completed DATA byte: B then A, most-significant byte first
      if (w_data_done) begin
        r_crc      <= w_crc_byte;
        r_data     <= {r_data[PKT_W-9:0], r_shift};
        r_byte_cnt <= w_byte_cnt_inc;
        if (!sin) r_poison <= 1'b1;
      end

      // Closing CTL frame: publish operands or report the error, then restart
      if (w_ctl_done) begin
        r_crc      <= '0;
        r_data     <= '0;
        r_byte_cnt <= '0;
        r_poison   <= 1'b0;
        if (w_err_vec == '0) begin
          valid  <= 1'b1;
          b_out  <= r_data[PKT_W-1 -: WORD_W];
          a_out  <= r_data[WORD_W-1:0];
          op_out <= w_ctl_op;
        end else begin
          err_valid <= 1'b1;
          err_out   <= w_err_vec;
        end
      end

      // Stale partial packets are dropped silently after a long idle gap
      if (TIMEOUT_CYC != 0) begin
        if ((r_state == ST_IDLE) && sin && w_pkt_active) begin
          if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            r_tmo      <= '0;
            r_crc      <= '0;
            r_data     <= '0;
            r_byte_cnt <= '0;
            r_poison   <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end else begin
          r_tmo <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_serial_rx.sv
// Directed bench for mtm_alu_serial_rx: a 32-bit LSB-first receiver with a short
// timeout, and a 16-bit MSB-first receiver with the timeout disabled.
module tb_mtm_alu_serial_rx;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sin0  = 1'b1;
  logic sin1  = 1'b1;

  logic [31:0] a0, b0;
  logic [2:0]  op0, err0;
  logic        v0, ev0;
  logic [15:0] a1, b1;
  logic [2:0]  op1, err1;
  logic        v1, ev1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [3:0]  xr;
    logic        ev;
    logic [2:0]  eerr;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [2:0]  eop;
  } vec_t;

  vec_t vt[13];

  always #5 clk = ~clk;

  mtm_alu_serial_rx #(.WORD_W(32), .LSB_FIRST(1'b1), .TIMEOUT_CYC(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .sin(sin0),
    .a_out(a0), .b_out(b0), .op_out(op0), .valid(v0),
    .err_out(err0), .err_valid(ev0)
  );

  mtm_alu_serial_rx #(.WORD_W(16), .LSB_FIRST(1'b0), .TIMEOUT_CYC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sin1),
    .a_out(a1), .b_out(b1), .op_out(op1), .valid(v1),
    .err_out(err1), .err_valid(ev1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference CRC-4 (x^4+x+1, init 0) over {B, A, 1, OP}, bit-serial MSB first
  function automatic logic [3:0] crc_model(input logic [63:0] b, input logic [63:0] a,
                                           input logic [2:0] op, input int nb);
    logic [3:0] c;
    logic [3:0] tail;
    logic       fb;
    c    = 4'h0;
    tail = {1'b1, op};
    for (int i = nb * 8 - 1; i >= 0; i--) begin
      fb = c[3] ^ b[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    for (int i = nb * 8 - 1; i >= 0; i--) begin
      fb = c[3] ^ a[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ tail[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  task automatic send_bit(input bit sel, input logic b);
    @(negedge clk);
    if (sel) sin1 = b;
    else     sin0 = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic cmd, input logic [7:0] byt,
                            input logic stop, input bit lsb);
    send_bit(sel, 1'b0);
    send_bit(sel, cmd);
    for (int i = 0; i < 8; i++) send_bit(sel, lsb ? byt[i] : byt[7-i]);
    send_bit(sel, stop);
  endtask

  task automatic send_packet(input bit sel, input logic [63:0] b, input logic [63:0] a,
                             input logic [2:0] op, input logic [3:0] xr, input int nb,
                             input int bad_stop, input logic ctl7,
                             input int gap_after, input int gap_len);
    logic [7:0] byt;
    logic [3:0] c;
    bit         lsb;
    lsb = !sel;
    for (int k = 0; k < 2 * nb; k++) begin
      if (k < nb) byt = b[(nb-1-k)*8 +: 8];
      else        byt = a[(2*nb-1-k)*8 +: 8];
      send_frame(sel, 1'b0, byt, (k != bad_stop), lsb);
      if (k == gap_after) idle(gap_len);
    end
    c = crc_model(b, a, op, nb) ^ xr;
    send_frame(sel, 1'b1, {ctl7, op, c}, 1'b1, lsb);
  endtask

  task automatic sample(input bit sel, output logic v, output logic e, output logic [2:0] er,
                        output logic [63:0] a, output logic [63:0] b, output logic [2:0] op);
    if (sel) begin
      v = v1; e = ev1; er = err1; a = {48'b0, a1}; b = {48'b0, b1}; op = op1;
    end else begin
      v = v0; e = ev0; er = err0; a = {32'b0, a0}; b = {32'b0, b0}; op = op0;
    end
  endtask

  // Called right after the CTL stop bit is driven: result must appear one cycle later, for one cycle
  task automatic check_result(input bit sel, input string name, input logic ev,
                              input logic [2:0] eerr, input logic [63:0] ea,
                              input logic [63:0] eb, input logic [2:0] eop);
    logic        v, e;
    logic [2:0]  er, op;
    logic [63:0] a, b;
    sample(sel, v, e, er, a, b, op);
    chk({name, ".early"}, {62'b0, v, e}, 64'd0);
    @(posedge clk); #1;
    sample(sel, v, e, er, a, b, op);
    chk({name, ".valid"},     64'(v),  64'(ev));
    chk({name, ".err_valid"}, 64'(e),  64'(!ev));
    chk({name, ".err_out"},   64'(er), 64'(eerr));
    chk({name, ".a_out"},     a,       ea);
    chk({name, ".b_out"},     b,       eb);
    chk({name, ".op_out"},    64'(op), 64'(eop));
    @(posedge clk); #1;
    sample(sel, v, e, er, a, b, op);
    chk({name, ".pulse_end"}, {62'b0, v, e}, 64'd0);
  endtask

  task automatic check_zero(input bit sel, input string name);
    logic        v, e;
    logic [2:0]  er, op;
    logic [63:0] a, b;
    sample(sel, v, e, er, a, b, op);
    chk({name, ".a_out"},  a, 64'd0);
    chk({name, ".b_out"},  b, 64'd0);
    chk({name, ".op_err"}, {58'b0, op, er}, 64'd0);
    chk({name, ".pulses"}, {62'b0, v, e}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{b:32'h3, a:32'h4, op:3'b100, xr:4'h0, ev:1'b1, eerr:3'b000, ea:32'h4, eb:32'h3, eop:3'b100};
    vt[1]  = '{b:32'h3, a:32'h4, op:3'b100, xr:4'h1, ev:1'b0, eerr:3'b010, ea:32'h4, eb:32'h3, eop:3'b100};
    vt[2]  = '{b:32'h3, a:32'h4, op:3'b010, xr:4'h0, ev:1'b0, eerr:3'b001, ea:32'h4, eb:32'h3, eop:3'b100};
    vt[3]  = '{b:32'h0, a:32'h0, op:3'b000, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'h0, eb:32'h0, eop:3'b000};
    vt[4]  = '{b:32'h0, a:32'h0, op:3'b001, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'h0, eb:32'h0, eop:3'b001};
    vt[5]  = '{b:32'h0, a:32'h0, op:3'b100, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'h0, eb:32'h0, eop:3'b100};
    vt[6]  = '{b:32'h0, a:32'h0, op:3'b101, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'h0, eb:32'h0, eop:3'b101};
    vt[7]  = '{b:32'hFFFFFFFF, a:32'hFFFFFFFF, op:3'b000, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'hFFFFFFFF, eb:32'hFFFFFFFF, eop:3'b000};
    vt[8]  = '{b:32'hFFFFFFFF, a:32'hFFFFFFFF, op:3'b001, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'hFFFFFFFF, eb:32'hFFFFFFFF, eop:3'b001};
    vt[9]  = '{b:32'hFFFFFFFF, a:32'hFFFFFFFF, op:3'b100, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'hFFFFFFFF, eb:32'hFFFFFFFF, eop:3'b100};
    vt[10] = '{b:32'hFFFFFFFF, a:32'hFFFFFFFF, op:3'b101, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'hFFFFFFFF, eb:32'hFFFFFFFF, eop:3'b101};
    vt[11] = '{b:32'h12345678, a:32'h9ABCDEF0, op:3'b100, xr:4'h0, ev:1'b1, eerr:3'b001, ea:32'h9ABCDEF0, eb:32'h12345678, eop:3'b100};
    vt[12] = '{b:32'h12345678, a:32'h9ABCDEF0, op:3'b111, xr:4'h1, ev:1'b0, eerr:3'b010, ea:32'h9ABCDEF0, eb:32'h12345678, eop:3'b100};

    // Power-on reset
    #1 rst_n = 1'b0;
    idle(3);
    check_zero(1'b0, "reset0");
    check_zero(1'b1, "reset1");
    rst_n = 1'b1;
    idle(2);

    // Table of complete packets on the 32-bit receiver
    for (int i = 0; i < 13; i++) begin
      send_packet(1'b0, {32'b0, vt[i].b}, {32'b0, vt[i].a}, vt[i].op, vt[i].xr, 4, -1, 1'b0, -1, 0);
      check_result(1'b0, $sformatf("row%0d", i), vt[i].ev, vt[i].eerr,
                   {32'b0, vt[i].ea}, {32'b0, vt[i].eb}, vt[i].eop);
    end

    // Too few DATA frames
    send_frame(1'b0, 1'b0, 8'h55, 1'b1, 1'b1);
    send_frame(1'b0, 1'b0, 8'h0F, 1'b1, 1'b1);
    send_frame(1'b0, 1'b1, 8'h50, 1'b1, 1'b1);
    check_result(1'b0, "two_data", 1'b0, 3'b100, 64'h9ABCDEF0, 64'h12345678, 3'b100);

    // Too many DATA frames
    for (int k = 0; k < 9; k++) send_frame(1'b0, 1'b0, 8'(k + 1), 1'b1, 1'b1);
    send_frame(1'b0, 1'b1, 8'h40, 1'b1, 1'b1);
    check_result(1'b0, "nine_data", 1'b0, 3'b100, 64'h9ABCDEF0, 64'h12345678, 3'b100);

    // CTL with no DATA at all
    send_frame(1'b0, 1'b1, 8'h40, 1'b1, 1'b1);
    check_result(1'b0, "zero_data", 1'b0, 3'b100, 64'h9ABCDEF0, 64'h12345678, 3'b100);

    // Bad stop bit on a DATA frame poisons an otherwise good packet
    send_packet(1'b0, 64'h3, 64'h4, 3'b100, 4'h0, 4, 2, 1'b0, -1, 0);
    check_result(1'b0, "bad_stop", 1'b0, 3'b100, 64'h9ABCDEF0, 64'h12345678, 3'b100);

    // CTL bit7 set
    send_packet(1'b0, 64'h3, 64'h4, 3'b100, 4'h0, 4, -1, 1'b1, -1, 0);
    check_result(1'b0, "ctl_bit7", 1'b0, 3'b100, 64'h9ABCDEF0, 64'h12345678, 3'b100);

    // Reset in the middle of frame 5
    for (int k = 0; k < 4; k++) send_frame(1'b0, 1'b0, 8'(k + 1), 1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sin0  = 1'b1;
    #1;
    check_zero(1'b0, "rst_mid");
    idle(2);
    rst_n = 1'b1;
    send_packet(1'b0, 64'hCAFEF00D, 64'h1, 3'b100, 4'h0, 4, -1, 1'b0, -1, 0);
    check_result(1'b0, "after_rst", 1'b1, 3'b000, 64'h1, 64'hCAFEF00D, 3'b100);

    // Stale bytes dropped after a long gap, new packet decodes
    for (int k = 0; k < 4; k++) send_frame(1'b0, 1'b0, 8'(8'h11 * (k + 1)), 1'b1, 1'b1);
    idle(20);
    send_packet(1'b0, 64'h01020304, 64'h05060708, 3'b101, 4'h0, 4, -1, 1'b0, -1, 0);
    check_result(1'b0, "tmo_stale", 1'b1, 3'b000, 64'h05060708, 64'h01020304, 3'b101);

    // Short gap inside a packet is tolerated
    send_packet(1'b0, 64'hA5A5A5A5, 64'h5A5A5A5A, 3'b001, 4'h0, 4, -1, 1'b0, 3, 12);
    check_result(1'b0, "short_gap", 1'b1, 3'b000, 64'h5A5A5A5A, 64'hA5A5A5A5, 3'b001);

    // Long gap inside a packet loses the first half
    send_packet(1'b0, 64'h01020304, 64'h05060708, 3'b100, 4'h0, 4, -1, 1'b0, 3, 20);
    check_result(1'b0, "long_gap", 1'b0, 3'b100, 64'h5A5A5A5A, 64'hA5A5A5A5, 3'b001);

    // 16-bit MSB-first receiver
    send_packet(1'b1, 64'hFFFF, 64'h0001, 3'b101, 4'h0, 2, -1, 1'b0, -1, 0);
    check_result(1'b1, "w16_sub", 1'b1, 3'b000, 64'h0001, 64'hFFFF, 3'b101);
    send_packet(1'b1, 64'h1234, 64'h00F0, 3'b100, 4'h0, 2, -1, 1'b0, -1, 0);
    check_result(1'b1, "w16_add", 1'b1, 3'b000, 64'h00F0, 64'h1234, 3'b100);
    send_packet(1'b1, 64'h1234, 64'h00F0, 3'b100, 4'h8, 2, -1, 1'b0, -1, 0);
    check_result(1'b1, "w16_crc", 1'b0, 3'b010, 64'h00F0, 64'h1234, 3'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
